// File: rtl/nonce_dispatcher.sv
// Multi-lane nonce source: hands out base nonces over an inclusive range, one per batch.
// Optional resume/load feature enabled by defining NONCE_LOAD_EN.
module nonce_dispatcher #(
  parameter int                 NONCE_W   = 32,
  parameter int                 NUM_LANES = 3,
  parameter logic [NONCE_W-1:0] START_VAL = '0,
  parameter logic [NONCE_W-1:0] END_VAL   = {NONCE_W{1'b1}}
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 found,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [NONCE_W-1:0]   base_nonce,
  output logic [NUM_LANES-1:0] lane_mask,
  output logic                 busy,
  output logic                 exhausted,
  output logic                 hit,
  output logic [31:0]          batch_count,
`ifdef NONCE_LOAD_EN
  input  logic                 load_en,
  input  logic [NONCE_W-1:0]   load_val,
`endif
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Range arithmetic is done one bit wider so an END_VAL of all ones never wraps.
  localparam logic [NONCE_W:0] END_EXT   = {1'b0, END_VAL};
  localparam logic [NONCE_W:0] START_EXT = {1'b0, START_VAL};
  localparam logic [NONCE_W:0] STEP      = (NONCE_W+1)'(NUM_LANES);

  state_t             state_q, state_d;
  logic [NONCE_W-1:0] base_q, base_d;
  logic               exh_q, exh_d;
  logic               hit_q, hit_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [NONCE_W:0]   next_ext;
  logic [31:0]        cnt_inc;
  logic [NONCE_W-1:0] start_base;

`ifdef NONCE_LOAD_EN
  logic [NONCE_W-1:0] resume_q, resume_d;
  logic               load_in_range;

  // Offset compare: anything below START_VAL wraps to a huge value and fails.
  assign load_in_range = (({1'b0, load_val} - START_EXT) <= (END_EXT - START_EXT));
  assign start_base    = resume_q;
`else
  assign start_base    = START_VAL;
`endif

  assign next_ext = {1'b0, base_q} + STEP;
  assign cnt_inc  = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

  // Handshake: a batch moves on any cycle with out_valid & out_ready; while out_valid
  // is high and out_ready low, base_nonce and lane_mask are held (all are register-driven).
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    exh_d   = exh_q;
    hit_d   = hit_q;
    cnt_d   = cnt_q;
`ifdef NONCE_LOAD_EN
    resume_d = resume_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE && abort) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = ST_RUN;
          base_d  = start_base;
          exh_d   = 1'b0;
          hit_d   = 1'b0;
          cnt_d   = 32'd0;
`ifdef NONCE_LOAD_EN
          resume_d = START_VAL;
`endif
        end
`ifdef NONCE_LOAD_EN
        else if (load_en) begin
          resume_d = load_in_range ? load_val : START_VAL;
        end
`endif
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (found) begin
          state_d = ST_DONE;
          hit_d   = 1'b1;
          if (out_ready) cnt_d = cnt_inc;
        end else if (out_ready) begin
          cnt_d = cnt_inc;
          if (next_ext > END_EXT) begin
            state_d = ST_DONE;
            exh_d   = 1'b1;
          end else begin
            base_d = next_ext[NONCE_W-1:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      base_q  <= START_VAL;
      exh_q   <= 1'b0;
      hit_q   <= 1'b0;
      cnt_q   <= 32'd0;
`ifdef NONCE_LOAD_EN
      resume_q <= START_VAL;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      exh_q   <= exh_d;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
`ifdef NONCE_LOAD_EN
      resume_q <= resume_d;
`endif
    end
  end

  // Lane i is live only while base+i still lies inside the range.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [NONCE_W:0] OFF = (NONCE_W+1)'(i);
    assign lane_mask[i] = (({1'b0, base_q} + OFF) <= END_EXT);
  end

  assign out_valid   = (state_q == ST_RUN);
  assign busy        = (state_q == ST_RUN);
  assign base_nonce  = base_q;
  assign exhausted   = exh_q;
  assign hit         = hit_q;
  assign batch_count = cnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Bench for nonce_dispatcher: three instances (default range, 0..7, 8-bit 252..255)
// share stimulus; each task checks one scenario against an arithmetic range model.
module tb_nonce_dispatcher;

  logic        clk = 1'b0;
  logic        n_rst, start, abort, found, out_ready;
`ifdef NONCE_LOAD_EN
  logic        load_en;
  logic [31:0] load_val;
`endif
  logic        ov[3], bsy[3], exh[3], hitv[3];
  logic [2:0]  msk[3];
  logic [31:0] bn[3], cnt[3];
  logic [7:0]  base_c;
  logic [1:0]  sd[3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nonce_dispatcher u_def (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .found(found),
    .out_ready(out_ready), .out_valid(ov[0]), .base_nonce(bn[0]), .lane_mask(msk[0]),
    .busy(bsy[0]), .exhausted(exh[0]), .hit(hitv[0]), .batch_count(cnt[0]),
`ifdef NONCE_LOAD_EN
    .load_en(load_en), .load_val(load_val),
`endif
    .state_dbg(sd[0])
  );

  nonce_dispatcher #(.NONCE_W(32), .NUM_LANES(3), .START_VAL(32'd0), .END_VAL(32'd7)) u_small (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .found(found),
    .out_ready(out_ready), .out_valid(ov[1]), .base_nonce(bn[1]), .lane_mask(msk[1]),
    .busy(bsy[1]), .exhausted(exh[1]), .hit(hitv[1]), .batch_count(cnt[1]),
`ifdef NONCE_LOAD_EN
    .load_en(load_en), .load_val(load_val),
`endif
    .state_dbg(sd[1])
  );

  nonce_dispatcher #(.NONCE_W(8), .NUM_LANES(3), .START_VAL(8'd252), .END_VAL(8'd255)) u_top (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .found(found),
    .out_ready(out_ready), .out_valid(ov[2]), .base_nonce(base_c), .lane_mask(msk[2]),
    .busy(bsy[2]), .exhausted(exh[2]), .hit(hitv[2]), .batch_count(cnt[2]),
`ifdef NONCE_LOAD_EN
    .load_en(load_en), .load_val(load_val[7:0]),
`endif
    .state_dbg(sd[2])
  );

  assign bn[2] = {24'd0, base_c};

  // Range model per instance
  function automatic longint s_of(input int idx);
    case (idx)
      2:       s_of = 252;
      default: s_of = 0;
    endcase
  endfunction

  function automatic longint e_of(input int idx);
    case (idx)
      0:       e_of = 64'd4294967295;
      1:       e_of = 7;
      default: e_of = 255;
    endcase
  endfunction

  function automatic logic [2:0] exp_mask(input longint b, input longint e);
    logic [2:0] m;
    for (int i = 0; i < 3; i++) m[i] = ((b + i) <= e);
    return m;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic go_idle();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  // Leaves us at the first negedge where the new scan is visible.
  task automatic start_scan();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (ov[i] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d] got %0b exp 0", i, ov[i]); end
      checks++; if (bsy[i] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got %0b exp 0", i, bsy[i]); end
      checks++; if (exh[i] !== 1'b0 || hitv[i] !== 1'b0) begin errors++; $display("FAIL reset_flags[%0d] got exh=%0b hit=%0b exp 0 0", i, exh[i], hitv[i]); end
      checks++; if (cnt[i] !== 32'd0) begin errors++; $display("FAIL reset_count[%0d] got %0d exp 0", i, cnt[i]); end
      checks++; if (bn[i] !== 32'(s_of(i))) begin errors++; $display("FAIL reset_base[%0d] got %0d exp %0d", i, bn[i], s_of(i)); end
    end
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_stream(input int idx, input int stall_pct, input int max_cycles);
    logic [31:0] exp_q[$];
    longint s, e, b;
    int exp_cnt, cyc;
    bit ranged_out, rdy;
    s = s_of(idx);
    e = e_of(idx);
    go_idle();
    out_ready = 1'b0;
    b = s;
    while (b <= e && exp_q.size() < max_cycles) begin
      exp_q.push_back(32'(b));
      b += 3;
    end
    ranged_out = (b > e);
    exp_cnt = 0;
    cyc = 0;
    start_scan();
    while (exp_q.size() > 0 && cyc < max_cycles) begin
      checks++; if (ov[idx] !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0b exp 1", idx, ov[idx]); end
      checks++; if (bn[idx] !== exp_q[0]) begin errors++; $display("FAIL stream_base[%0d] got %0d exp %0d", idx, bn[idx], exp_q[0]); end
      checks++; if (msk[idx] !== exp_mask(longint'(exp_q[0]), e)) begin errors++; $display("FAIL stream_mask[%0d] got %b exp %b", idx, msk[idx], exp_mask(longint'(exp_q[0]), e)); end
      checks++; if (cnt[idx] !== 32'(exp_cnt)) begin errors++; $display("FAIL stream_count[%0d] got %0d exp %0d", idx, cnt[idx], exp_cnt); end
      checks++; if (exh[idx] !== 1'b0) begin errors++; $display("FAIL stream_exh_early[%0d] got %0b exp 0", idx, exh[idx]); end
      rdy = ($urandom_range(0, 99) >= stall_pct);
      out_ready = rdy;
      tick();
      cyc++;
      if (rdy) begin
        void'(exp_q.pop_front());
        exp_cnt++;
      end
    end
    out_ready = 1'b0;
    if (ranged_out) begin
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_budget[%0d] got %0d left exp 0", idx, exp_q.size()); end
      checks++; if (ov[idx] !== 1'b0 || bsy[idx] !== 1'b0) begin errors++; $display("FAIL done_idle[%0d] got valid=%0b busy=%0b exp 0 0", idx, ov[idx], bsy[idx]); end
      checks++; if (exh[idx] !== 1'b1) begin errors++; $display("FAIL done_exhausted[%0d] got %0b exp 1", idx, exh[idx]); end
      checks++; if (cnt[idx] !== 32'(exp_cnt)) begin errors++; $display("FAIL done_count[%0d] got %0d exp %0d", idx, cnt[idx], exp_cnt); end
      found = 1'b1;
      tick();
      found = 1'b0;
      checks++; if (hitv[idx] !== 1'b0 || exh[idx] !== 1'b1) begin errors++; $display("FAIL done_found_ignored[%0d] got hit=%0b exh=%0b exp 0 1", idx, hitv[idx], exh[idx]); end
    end
  endtask

  task automatic test_stall_found();
    go_idle();
    out_ready = 1'b1;
    start_scan();
    repeat (3) tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (ov[0] !== 1'b1 || bn[0] !== 32'd9) begin errors++; $display("FAIL stall_hold got valid=%0b base=%0d exp 1 9", ov[0], bn[0]); end
    end
    out_ready = 1'b1;
    tick();
    checks++; if (bn[0] !== 32'd12 || cnt[0] !== 32'd4) begin errors++; $display("FAIL stall_release got base=%0d cnt=%0d exp 12 4", bn[0], cnt[0]); end
    found = 1'b1;
    tick();
    found = 1'b0;
    out_ready = 1'b0;
    checks++; if (ov[0] !== 1'b0 || bsy[0] !== 1'b0) begin errors++; $display("FAIL found_done got valid=%0b busy=%0b exp 0 0", ov[0], bsy[0]); end
    checks++; if (hitv[0] !== 1'b1 || exh[0] !== 1'b0) begin errors++; $display("FAIL found_flags got hit=%0b exh=%0b exp 1 0", hitv[0], exh[0]); end
    checks++; if (bn[0] !== 32'd12 || cnt[0] !== 32'd5) begin errors++; $display("FAIL found_base_cnt got base=%0d cnt=%0d exp 12 5", bn[0], cnt[0]); end
  endtask

  task automatic test_found_abort();
    out_ready = 1'b1;
    start_scan();
    checks++; if (cnt[0] !== 32'd0 || hitv[0] !== 1'b0 || bn[0] !== 32'd0) begin errors++; $display("FAIL restart_init got cnt=%0d hit=%0b base=%0d exp 0 0 0", cnt[0], hitv[0], bn[0]); end
    tick();
    found = 1'b1;
    abort = 1'b1;
    tick();
    found = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    checks++; if (ov[0] !== 1'b0 || bsy[0] !== 1'b0) begin errors++; $display("FAIL abort_idle got valid=%0b busy=%0b exp 0 0", ov[0], bsy[0]); end
    checks++; if (hitv[0] !== 1'b0) begin errors++; $display("FAIL abort_hit got %0b exp 0", hitv[0]); end
    checks++; if (bn[0] !== 32'd3) begin errors++; $display("FAIL abort_base got %0d exp 3", bn[0]); end
  endtask

  task automatic test_ignored();
    go_idle();
    out_ready = 1'b1;
    start_scan();
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (bn[0] !== 32'd15 || cnt[0] !== 32'd5) begin errors++; $display("FAIL start_in_run got base=%0d cnt=%0d exp 15 5", bn[0], cnt[0]); end
    out_ready = 1'b0;
    go_idle();
    found = 1'b1;
    tick();
    found = 1'b0;
    checks++; if (ov[0] !== 1'b0 || hitv[0] !== 1'b0) begin errors++; $display("FAIL found_in_idle got valid=%0b hit=%0b exp 0 0", ov[0], hitv[0]); end
  endtask

  task automatic test_reset_mid_run();
    go_idle();
    out_ready = 1'b1;
    start_scan();
    repeat (3) tick();
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ov[i] !== 1'b0 || bsy[i] !== 1'b0) begin errors++; $display("FAIL midrst_idle[%0d] got valid=%0b busy=%0b exp 0 0", i, ov[i], bsy[i]); end
      checks++; if (cnt[i] !== 32'd0 || exh[i] !== 1'b0 || hitv[i] !== 1'b0) begin errors++; $display("FAIL midrst_clear[%0d] got cnt=%0d exh=%0b hit=%0b exp 0 0 0", i, cnt[i], exh[i], hitv[i]); end
      checks++; if (bn[i] !== 32'(s_of(i))) begin errors++; $display("FAIL midrst_base[%0d] got %0d exp %0d", i, bn[i], s_of(i)); end
    end
    tick();
    out_ready = 1'b0;
    checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL midrst_stays_idle got %0b exp 0", ov[0]); end
  endtask

`ifdef NONCE_LOAD_EN
  task automatic test_load();
    go_idle();
    load_en = 1'b1;
    load_val = 32'd100;
    tick();
    load_en = 1'b0;
    start_scan();
    checks++; if (bn[0] !== 32'd100) begin errors++; $display("FAIL load_base got %0d exp 100", bn[0]); end
    checks++; if (bn[1] !== 32'd0) begin errors++; $display("FAIL load_clamp_hi got %0d exp 0", bn[1]); end
    checks++; if (bn[2] !== 32'd252) begin errors++; $display("FAIL load_clamp_lo got %0d exp 252", bn[2]); end
    load_en = 1'b1;
    load_val = 32'd50;
    tick();
    load_en = 1'b0;
    go_idle();
    start_scan();
    checks++; if (bn[0] !== 32'd0) begin errors++; $display("FAIL load_resume_reset got %0d exp 0", bn[0]); end
    go_idle();
    load_en = 1'b1;
    load_val = 32'd254;
    tick();
    load_en = 1'b0;
    start_scan();
    checks++; if (bn[2] !== 32'd254 || msk[2] !== exp_mask(254, 255)) begin errors++; $display("FAIL load_top got base=%0d mask=%b exp 254 %b", bn[2], msk[2], exp_mask(254, 255)); end
    go_idle();
  endtask
`endif

  initial begin
    n_rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    found = 1'b0;
    out_ready = 1'b0;
`ifdef NONCE_LOAD_EN
    load_en = 1'b0;
    load_val = 32'd0;
`endif
    test_reset();
    test_stream(0, 0, 20);
    test_stream(0, 40, 60);
    test_stream(1, 0, 10);
    test_stream(1, 50, 80);
    test_stream(2, 0, 10);
    test_stream(2, 30, 80);
    test_stall_found();
    test_found_abort();
    test_ignored();
    test_reset_mid_run();
`ifdef NONCE_LOAD_EN
    test_load();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
